sdu_dump: RTL

SDU_DUMP -- requirements
Module: sdu_dump

---
 rtl/sdu_dump.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sdu_dump.sv
// rtl/sdu_dump.sv - ASCII hex dump of NCH snapshotted channel words toward a byte transmitter
// Optional trailing checksum line enabled by SDU_DUMP_CHKSUM_EN.
module sdu_dump #(
    parameter int NCH = 8,
    parameter int W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NCH*W-1:0] data_in,
    output logic [7:0]       d_tx,
    output logic             vld_tx,
    input  logic             rdy_tx,
    output logic             busy,
    output logic             done
);

    localparam int         ND       = W / 4;
    localparam logic [3:0] LAST_CH  = 4'(NCH - 1);
    localparam logic [3:0] LAST_NIB = 4'(ND - 1);

`ifdef SDU_DUMP_CHKSUM_EN
    typedef enum logic [3:0] {
        IDLE, IDX, COLON, DIGIT, CR, LF, END, CHK_HI, CHK_LO, CHK_CR, CHK_LF
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, IDX, COLON, DIGIT, CR, LF, END
    } state_t;
`endif

    state_t             state, state_next;
    logic [3:0]         ch;
    logic [3:0]         nib;
    logic [NCH*W-1:0]   snap;
    logic [W-1:0]       cur_word;
    logic [3:0]         cur_nib;
    logic               in_dump;
    logic               xfer;

    function automatic logic [7:0] hex(input logic [3:0] v);
        return (v < 4'd10) ? {4'h3, v} : 8'(8'h37 + {4'h0, v});
    endfunction

    assign in_dump = (state != IDLE) && (state != END);
    assign vld_tx  = in_dump;
    assign busy    = in_dump;
    assign done    = (state == END);
    assign xfer    = in_dump && rdy_tx;

`ifdef SDU_DUMP_CHKSUM_EN
    logic [7:0] sum;
    logic       in_body;

    // Only the channel lines contribute; the checksum line itself is excluded.
    assign in_body = (state == IDX) || (state == COLON) || (state == DIGIT) ||
                     (state == CR)  || (state == LF);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= 8'h00;
        end else if (state == IDLE && start) begin
            sum <= 8'h00;
        end else if (xfer && in_body) begin
            sum <= sum + d_tx;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ch    <= 4'd0;
            nib   <= 4'd0;
            snap  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                snap <= data_in;
                ch   <= 4'd0;
                nib  <= LAST_NIB;
            end else if (xfer && state == DIGIT) begin
                nib <= nib - 4'd1;
            end else if (xfer && state == LF && ch != LAST_CH) begin
                ch  <= ch + 4'd1;
                nib <= LAST_NIB;
            end
        end
    end

    always_comb begin
        cur_word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch == 4'(i)) cur_word = snap[i*W +: W];
        end
        cur_nib = 4'h0;
        for (int j = 0; j < ND; j++) begin
            if (nib == 4'(j)) cur_nib = cur_word[j*4 +: 4];
        end
    end

    always_comb begin
        state_next = state;
        d_tx       = 8'h00;
        case (state)
            IDLE: begin
                if (start) state_next = IDX;
            end
            IDX: begin
                d_tx = hex(ch);
                if (xfer) state_next = COLON;
            end
            COLON: begin
                d_tx = 8'h3A;
                if (xfer) state_next = DIGIT;
            end
            DIGIT: begin
                d_tx = hex(cur_nib);
                if (xfer && nib == 4'd0) state_next = CR;
            end
            CR: begin
                d_tx = 8'h0D;
                if (xfer) state_next = LF;
            end
            LF: begin
                d_tx = 8'h0A;
                if (xfer) begin
                    if (ch != LAST_CH) begin
                        state_next = IDX;
                    end else begin
`ifdef SDU_DUMP_CHKSUM_EN
                        state_next = CHK_HI;
`else
                        state_next = END;
`endif
                    end
                end
            end
`ifdef SDU_DUMP_CHKSUM_EN
            CHK_HI: begin
                d_tx = hex(sum[7:4]);
                if (xfer) state_next = CHK_LO;
            end
            CHK_LO: begin
                d_tx = hex(sum[3:0]);
                if (xfer) state_next = CHK_CR;
            end
            CHK_CR: begin
                d_tx = 8'h0D;
                if (xfer) state_next = CHK_LF;
            end
            CHK_LF: begin
                d_tx = 8'h0A;
                if (xfer) state_next = END;
            end
`endif
            END: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
